// File: rtl/sw_txbuf_pac.sv
// Single-flow software TX buffer.
// Software fills a circular word buffer over the write port and then queues
// byte lengths; each length becomes one FrameLink frame read from the buffer
// at the read pointer, and the rounded-up byte count is released afterwards.
//
// state | meaning
// IDLE  | waiting for a queued length; zero lengths are popped and dropped
// PREP  | first word read in flight through the registered memory output
// SEND  | words presented on FrameLink, one per accepted cycle
module sw_txbuf_pac #(
    parameter int DATA_WIDTH     = 64,
    parameter int BLOCK_SIZE     = 512,
    parameter int LEN_FIFO_DEPTH = 16
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [31:0]                       WR_ADDR,
    input  logic [DATA_WIDTH-1:0]             WR_DATA,
    input  logic [DATA_WIDTH/8-1:0]           WR_BE,
    input  logic                              WR_REQ,
    output logic                              WR_RDY,
    input  logic [15:0]                       TX_NEWLEN,
    input  logic                              TX_NEWLEN_DV,
    output logic                              TX_NEWLEN_RDY,
    output logic [15:0]                       TX_RELLEN,
    output logic                              TX_RELLEN_DV,
    output logic [DATA_WIDTH-1:0]             TX_DATA,
    output logic [$clog2(DATA_WIDTH/8)-1:0]   TX_REM,
    output logic                              TX_SOF_N,
    output logic                              TX_EOF_N,
    output logic                              TX_SOP_N,
    output logic                              TX_EOP_N,
    output logic                              TX_SRC_RDY_N,
    input  logic                              TX_DST_RDY_N
);

    localparam int BW  = DATA_WIDTH / 8;
    localparam int LBW = $clog2(BW);
    localparam int AW  = $clog2(BLOCK_SIZE);
    localparam int FAW = $clog2(LEN_FIFO_DEPTH);
    localparam int FPW = FAW + 1;
    // width of a frame length expressed in words
    localparam int WL  = 17 - LBW;

    typedef enum logic [1:0] {IDLE, PREP, SEND} state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [BLOCK_SIZE];
    logic [DATA_WIDTH-1:0] mem_q;
    logic [AW-1:0]         wr_word;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         rd_addr;
    logic                  mem_rd_en;

    logic [15:0]           len_fifo [LEN_FIFO_DEPTH];
    logic [FPW-1:0]        fifo_wp, fifo_rp;
    logic                  fifo_full, fifo_empty;
    logic                  fifo_push, fifo_pop;
    logic                  rdy_en;
    logic [15:0]           head_len;
    logic [16:0]           head_sum;
    logic [WL-1:0]         head_words;

    logic [WL-1:0]         frm_words;
    logic [WL-1:0]         word_idx;
    logic [LBW-1:0]        frm_rem;
    logic                  last_word;
    logic                  frame_go;
    logic                  accept;
    logic                  frame_done;
    logic                  sof_n, eof_n;

    logic                  unused_bits;

    assign WR_RDY      = 1'b1;
    assign wr_word     = WR_ADDR[LBW+AW-1:LBW];
    assign unused_bits = &{1'b0, WR_ADDR[31:LBW+AW], WR_ADDR[LBW-1:0], head_sum[LBW-1:0]};

    assign fifo_empty    = (fifo_wp == fifo_rp);
    assign fifo_full     = (fifo_wp[FAW] != fifo_rp[FAW]) &&
                           (fifo_wp[FAW-1:0] == fifo_rp[FAW-1:0]);
    assign TX_NEWLEN_RDY = rdy_en && !fifo_full;
    assign fifo_push     = TX_NEWLEN_DV && TX_NEWLEN_RDY;
    assign head_len      = len_fifo[fifo_rp[FAW-1:0]];
    assign head_sum      = {1'b0, head_len} + 17'(BW - 1);
    assign head_words    = head_sum[16:LBW];

    assign last_word  = (word_idx == frm_words - WL'(1));
    assign accept     = !TX_SRC_RDY_N && !TX_DST_RDY_N;
    assign frame_done = accept && last_word;

    assign TX_DATA  = mem_q;
    assign TX_SOF_N = sof_n;
    assign TX_SOP_N = sof_n;
    assign TX_EOF_N = eof_n;
    assign TX_EOP_N = eof_n;

    // Byte-masked buffer write; contents are not reset.
    always_ff @(posedge CLK) begin
        if (WR_REQ) begin
            for (int b = 0; b < BW; b++) begin
                if (WR_BE[b]) mem[wr_word][b*8 +: 8] <= WR_DATA[b*8 +: 8];
            end
        end
    end

    // Length FIFO storage.
    always_ff @(posedge CLK) begin
        if (fifo_push) len_fifo[fifo_wp[FAW-1:0]] <= TX_NEWLEN;
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_go) state_nxt = PREP;
            PREP:    state_nxt = SEND;
            SEND:    if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: FIFO pop, memory read enable and FrameLink control.
    always_comb begin
        fifo_pop     = 1'b0;
        frame_go     = 1'b0;
        mem_rd_en    = 1'b0;
        TX_SRC_RDY_N = 1'b1;
        sof_n        = 1'b1;
        eof_n        = 1'b1;
        TX_REM       = '0;
        case (state)
            IDLE: begin
                fifo_pop = !fifo_empty;
                frame_go = !fifo_empty && (head_len != 16'd0);
            end
            PREP: mem_rd_en = 1'b1;
            SEND: begin
                TX_SRC_RDY_N = 1'b0;
                mem_rd_en    = !TX_DST_RDY_N;
                sof_n        = (word_idx != '0);
                eof_n        = !last_word;
                TX_REM       = last_word ? frm_rem : '1;
            end
            default: ;
        endcase
    end

    // Datapath: FIFO pointers, read address pipeline, frame tracking, release.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rdy_en       <= 1'b0;
            fifo_wp      <= '0;
            fifo_rp      <= '0;
            rd_ptr       <= '0;
            rd_addr      <= '0;
            mem_q        <= '0;
            word_idx     <= '0;
            frm_words    <= '0;
            frm_rem      <= '0;
            TX_RELLEN    <= '0;
            TX_RELLEN_DV <= 1'b0;
        end else begin
            rdy_en       <= 1'b1;
            TX_RELLEN_DV <= frame_done;
            if (fifo_push) fifo_wp <= fifo_wp + FPW'(1);
            if (fifo_pop)  fifo_rp <= fifo_rp + FPW'(1);
            if (frame_go) begin
                rd_addr   <= rd_ptr;
                word_idx  <= '0;
                frm_words <= head_words;
                frm_rem   <= head_len[LBW-1:0] - LBW'(1);
            end
            // read advances only when the presented word is consumed, so a
            // stalled output keeps both data and address frozen
            if (mem_rd_en) begin
                mem_q   <= mem[rd_addr];
                rd_addr <= rd_addr + AW'(1);
            end
            if (accept) word_idx <= word_idx + WL'(1);
            if (frame_done) begin
                rd_ptr    <= rd_ptr + AW'(frm_words);
                TX_RELLEN <= 16'({frm_words, {LBW{1'b0}}});
            end
        end
    end

endmodule

// File: tb/tb_sw_txbuf_pac.sv
module tb_sw_txbuf_pac;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] WR_ADDR;
    logic [63:0] WR_DATA;
    logic [7:0]  WR_BE;
    logic        WR_REQ;
    logic        WR_RDY;
    logic [15:0] TX_NEWLEN;
    logic        TX_NEWLEN_DV;
    logic        TX_NEWLEN_RDY;
    logic [15:0] TX_RELLEN;
    logic        TX_RELLEN_DV;
    logic [63:0] TX_DATA;
    logic [2:0]  TX_REM;
    logic        TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N;
    logic        TX_SRC_RDY_N;
    logic        TX_DST_RDY_N;

    int n_cmp = 0;
    int n_bad = 0;

    sw_txbuf_pac #(.DATA_WIDTH(64), .BLOCK_SIZE(512), .LEN_FIFO_DEPTH(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_BE(WR_BE), .WR_REQ(WR_REQ), .WR_RDY(WR_RDY),
        .TX_NEWLEN(TX_NEWLEN), .TX_NEWLEN_DV(TX_NEWLEN_DV), .TX_NEWLEN_RDY(TX_NEWLEN_RDY),
        .TX_RELLEN(TX_RELLEN), .TX_RELLEN_DV(TX_RELLEN_DV),
        .TX_DATA(TX_DATA), .TX_REM(TX_REM),
        .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N), .TX_SOP_N(TX_SOP_N), .TX_EOP_N(TX_EOP_N),
        .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
        WR_ADDR = a; WR_DATA = d; WR_BE = be; WR_REQ = 1'b1;
        @(negedge CLK);
        WR_REQ = 1'b0;
    endtask

    task automatic push_len(input logic [15:0] l);
        TX_NEWLEN = l; TX_NEWLEN_DV = 1'b1;
        @(negedge CLK);
        TX_NEWLEN_DV = 1'b0;
    endtask

    task automatic wait_sof(input string tag);
        for (int i = 0; i < 20 && TX_SRC_RDY_N; i++) @(negedge CLK);
        chk(tag, TX_SRC_RDY_N, 1'b0);
    endtask

    task automatic check_word(input string tag, input logic [63:0] d,
                              input logic sof_n, input logic eof_n, input logic [2:0] rem);
        chk({tag, "_src"},  TX_SRC_RDY_N, 1'b0);
        chk({tag, "_data"}, TX_DATA, d);
        chk({tag, "_sof"},  {TX_SOF_N, TX_SOP_N}, {sof_n, sof_n});
        chk({tag, "_eof"},  {TX_EOF_N, TX_EOP_N}, {eof_n, eof_n});
        chk({tag, "_rem"},  TX_REM, rem);
    endtask

    int          cnt, rel, acc;
    logic        done;
    logic [63:0] got_data;
    logic [4:0]  got_flags;
    logic [15:0] got_rel;

    initial begin
        RESET = 1'b0; WR_ADDR = '0; WR_DATA = '0; WR_BE = '0; WR_REQ = 1'b0;
        TX_NEWLEN = '0; TX_NEWLEN_DV = 1'b0; TX_DST_RDY_N = 1'b0;
        repeat (2) @(negedge CLK);

        // reset state
        chk("rst_src",    TX_SRC_RDY_N, 1'b1);
        chk("rst_delim",  {TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N}, 4'hF);
        chk("rst_rel",    {TX_RELLEN_DV, TX_RELLEN}, 17'd0);
        chk("rst_data",   TX_DATA, 64'd0);
        chk("rst_rem",    TX_REM, 3'd0);
        chk("rst_newrdy", TX_NEWLEN_RDY, 1'b0);
        chk("wr_rdy",     WR_RDY, 1'b1);
        RESET = 1'b1;
        chk("rel_newrdy0", TX_NEWLEN_RDY, 1'b0);
        @(negedge CLK);
        chk("rel_newrdy1", TX_NEWLEN_RDY, 1'b1);

        // basic frame, with ignored high address bits and a partial byte write
        wr(32'h0000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF);
        wr(32'h0001_0008, 64'h1111_2222_3333_4444, 8'hFF);
        wr(32'h0000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF);
        wr(32'h0000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        push_len(16'd20);
        chk("t1_lat1", TX_SRC_RDY_N, 1'b1);
        @(negedge CLK);
        chk("t1_lat2", TX_SRC_RDY_N, 1'b1);
        @(negedge CLK);
        check_word("t1_w0", 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 3'd7);
        @(negedge CLK);
        check_word("t1_w1", 64'h1111_2222_3333_4444, 1'b1, 1'b1, 3'd7);
        @(negedge CLK);
        check_word("t1_w2", 64'hAAAA_BBBB_FFFF_FFFF, 1'b1, 1'b0, 3'd3);
        @(negedge CLK);
        chk("t1_rel", {TX_RELLEN_DV, TX_RELLEN}, {1'b1, 16'd24});
        chk("t1_idle", TX_SRC_RDY_N, 1'b1);
        @(negedge CLK);
        chk("t1_rel_pulse", TX_RELLEN_DV, 1'b0);

        // backpressure on the second word; read pointer is now 3
        wr(32'd24, 64'hE3E3_0000_0000_0003, 8'hFF);
        wr(32'd32, 64'hE4E4_0000_0000_0004, 8'hFF);
        wr(32'd40, 64'hE5E5_0000_0000_0005, 8'hFF);
        push_len(16'd24);
        wait_sof("t2_start");
        check_word("t2_w0", 64'hE3E3_0000_0000_0003, 1'b0, 1'b1, 3'd7);
        @(negedge CLK);
        check_word("t2_w1", 64'hE4E4_0000_0000_0004, 1'b1, 1'b1, 3'd7);
        TX_DST_RDY_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check_word("t2_hold", 64'hE4E4_0000_0000_0004, 1'b1, 1'b1, 3'd7);
        end
        TX_DST_RDY_N = 1'b0;
        @(negedge CLK);
        check_word("t2_w2", 64'hE5E5_0000_0000_0005, 1'b1, 1'b0, 3'd7);
        @(negedge CLK);
        chk("t2_rel", {TX_RELLEN_DV, TX_RELLEN, TX_SRC_RDY_N}, {1'b1, 16'd24, 1'b1});

        // zero length followed by one-word frame; read pointer is now 6
        wr(32'd48, 64'hF6F6_F6F6_0000_0006, 8'hFF);
        TX_NEWLEN = 16'd0; TX_NEWLEN_DV = 1'b1;
        @(negedge CLK);
        TX_NEWLEN = 16'd8;
        @(negedge CLK);
        TX_NEWLEN_DV = 1'b0;
        cnt = 0; rel = 0; got_data = '0; got_flags = '0; got_rel = '0;
        for (int i = 0; i < 12; i++) begin
            if (!TX_SRC_RDY_N) begin
                cnt++;
                got_data  = TX_DATA;
                got_flags = {TX_SOF_N, TX_EOF_N, TX_REM};
            end
            if (TX_RELLEN_DV) begin
                rel++;
                got_rel = TX_RELLEN;
            end
            @(negedge CLK);
        end
        chk("t3_words", cnt, 1);
        chk("t3_rels",  rel, 1);
        chk("t3_data",  got_data, 64'hF6F6_F6F6_0000_0006);
        chk("t3_flags", got_flags, {1'b0, 1'b0, 3'd7});
        chk("t3_rellen", got_rel, 16'd8);

        // long frame to bring the read pointer from 7 to 510
        push_len(16'd4024);
        wait_sof("t4a_start");
        cnt = 0; done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            if (!TX_SRC_RDY_N) begin
                cnt++;
                if (!TX_EOF_N) done = 1'b1;
            end
            @(negedge CLK);
        end
        chk("t4a_words", cnt, 503);
        chk("t4a_rel", {TX_RELLEN_DV, TX_RELLEN}, {1'b1, 16'd4024});

        // wrap-around frame: words 510, 511, 0, 1
        wr(32'd4080, 64'h5100_0000_0000_0510, 8'hFF);
        wr(32'd4088, 64'h5110_0000_0000_0511, 8'hFF);
        wr(32'd0,    64'h0000_0000_0000_0A00, 8'hFF);
        wr(32'd8,    64'h0000_0000_0000_0A01, 8'hFF);
        push_len(16'd32);
        wait_sof("t4_start");
        check_word("t4_w510", 64'h5100_0000_0000_0510, 1'b0, 1'b1, 3'd7);
        @(negedge CLK);
        check_word("t4_w511", 64'h5110_0000_0000_0511, 1'b1, 1'b1, 3'd7);
        @(negedge CLK);
        check_word("t4_w0",   64'h0000_0000_0000_0A00, 1'b1, 1'b1, 3'd7);
        @(negedge CLK);
        check_word("t4_w1",   64'h0000_0000_0000_0A01, 1'b1, 1'b0, 3'd7);
        @(negedge CLK);
        chk("t4_rel", {TX_RELLEN_DV, TX_RELLEN}, {1'b1, 16'd32});
        wr(32'd16, 64'h0000_0000_0000_0A02, 8'hFF);
        push_len(16'd8);
        wait_sof("t4_ptr_start");
        check_word("t4_ptr2", 64'h0000_0000_0000_0A02, 1'b0, 1'b0, 3'd7);

        // FIFO full under held backpressure; read pointer is now 3
        @(negedge CLK);
        TX_DST_RDY_N = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            TX_NEWLEN = 16'd8; TX_NEWLEN_DV = 1'b1;
            if (TX_NEWLEN_RDY) acc++;
            @(negedge CLK);
        end
        TX_NEWLEN_DV = 1'b0;
        chk("t5_accepted", acc, 17);
        repeat (3) @(negedge CLK);
        chk("t5_rdy_full", TX_NEWLEN_RDY, 1'b0);
        chk("t5_stalled",  TX_SRC_RDY_N, 1'b0);
        TX_DST_RDY_N = 1'b0;
        rel = 0;
        @(negedge CLK);
        if (TX_RELLEN_DV) rel++;
        chk("t5_rdy_after_eof", TX_NEWLEN_RDY, 1'b0);
        @(negedge CLK);
        if (TX_RELLEN_DV) rel++;
        chk("t5_rdy_after_pop", TX_NEWLEN_RDY, 1'b1);
        for (int i = 0; i < 150; i++) begin
            @(negedge CLK);
            if (TX_RELLEN_DV) rel++;
        end
        chk("t5_frames", rel, 17);

        // reset in the middle of a frame; read pointer is now 20
        wr(32'd160, 64'h6000_0000_0000_0020, 8'hFF);
        wr(32'd168, 64'h6000_0000_0000_0021, 8'hFF);
        push_len(16'd16);
        wait_sof("t6_start");
        TX_DST_RDY_N = 1'b1;
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        chk("t6_src",    TX_SRC_RDY_N, 1'b1);
        chk("t6_delim",  {TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N}, 4'hF);
        chk("t6_data",   TX_DATA, 64'd0);
        chk("t6_rem",    TX_REM, 3'd0);
        chk("t6_rel",    {TX_RELLEN_DV, TX_RELLEN}, 17'd0);
        chk("t6_newrdy", TX_NEWLEN_RDY, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        TX_DST_RDY_N = 1'b0;
        chk("t6_newrdy_rel0", TX_NEWLEN_RDY, 1'b0);
        @(negedge CLK);
        chk("t6_newrdy_rel1", TX_NEWLEN_RDY, 1'b1);
        wr(32'd0, 64'h7777_0000_0000_0000, 8'hFF);
        push_len(16'd8);
        wait_sof("t6_after_start");
        check_word("t6_w0", 64'h7777_0000_0000_0000, 1'b0, 1'b0, 3'd7);
        @(negedge CLK);
        chk("t6_after_rel", {TX_RELLEN_DV, TX_RELLEN}, {1'b1, 16'd8});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sw_txbuf_pac.md
SW_TXBUF_PAC -- requirements
Module: sw_txbuf_pac

Single-flow software TX buffer. Software writes frame data through the internal-bus write port, then announces each frame's byte length. The block transmits each frame on FrameLink and reports freed space.

Interface
REQ-001 Parameters (name, default, meaning), one per line SHALL be:
  DATA_WIDTH  64  data width in bits; BW = DATA_WIDTH/8 bytes per word
  BLOCK_SIZE  512  circular buffer depth in words, power of 2
  LEN_FIFO_DEPTH  16  number of pending lengths, power of 2
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  CLK  in  1  sole clock, rising edge
  RESET  in  1  reset, asynchronous, active-low
  WR_ADDR  in  32  byte address into buffer
  WR_DATA  in  DATA_WIDTH  write data
  WR_BE  in  BW  byte enables
  WR_REQ  in  1  write strobe
  WR_RDY  out  1  write accepted
  TX_NEWLEN  in  16  byte length of a frame already written
  TX_NEWLEN_DV  in  1  TX_NEWLEN valid
  TX_NEWLEN_RDY  out  1  length can be accepted
  TX_RELLEN  out  16  bytes released after a frame is sent
  TX_RELLEN_DV  out  1  TX_RELLEN valid, 1-cycle pulse
  TX_DATA  out  DATA_WIDTH  FrameLink data
  TX_REM  out  log2(BW)  index of the last valid byte
  TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  1 each  frame/part delimiters, active-low
  TX_SRC_RDY_N  out  1  source ready, active-low
  TX_DST_RDY_N  in  1  destination ready, active-low

Function
REQ-003 WR_RDY SHALL be constant 1; a write with WR_REQ=1 SHALL update, in the same cycle, the buffer word at WR_ADDR[log2(BW)+log2(BLOCK_SIZE)-1 : log2(BW)], bytes masked by WR_BE; higher address bits SHALL be ignored.
REQ-004 A length SHALL be accepted when TX_NEWLEN_DV=1 and TX_NEWLEN_RDY=1; TX_NEWLEN_RDY SHALL be 0 exactly when the length FIFO is full.
REQ-005 A length of 0 SHALL be accepted and discarded: no frame is sent and no TX_RELLEN is produced.
REQ-006 Each frame SHALL be one part: SOP equals SOF, and EOP equals EOF.
REQ-007 Each frame SHALL occupy W = ceil(len/BW) words starting at the read pointer.
REQ-008 After a frame's EOF word is accepted, the read pointer SHALL advance by W modulo BLOCK_SIZE.
REQ-009 FSM states SHALL be IDLE, PREP and SEND:
  IDLE -> PREP when the FIFO is non-empty: pop the length, issue the first memory read.
  PREP -> SEND after the 1-cycle registered memory latency.
  SEND -> IDLE when the EOF word is accepted.
REQ-010 TX_SRC_RDY_N SHALL be 0 only in SEND. A word is accepted when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0.
REQ-011 While TX_DST_RDY_N=1, TX_DATA, TX_REM and the delimiters SHALL hold stable, and no read address SHALL advance.
REQ-012 Throughput SHALL be 1 word/cycle within a frame. The first SOF SHALL appear 2 cycles after the length is popped.
REQ-013 TX_REM SHALL be (len-1) mod BW on the EOF word and all-ones on other words.
REQ-014 When a frame's EOF word is accepted, TX_RELLEN SHALL be W*BW and TX_RELLEN_DV SHALL be 1 in the next cycle.
REQ-015 The block SHALL NOT check for overwrite of unreleased space; lengths above BLOCK_SIZE*BW are a software error.
REQ-016 Write and read of the same word in the same cycle SHALL complete the write; the read value is then undefined.

Reset
REQ-017 RESET=0 SHALL asynchronously force:
  - FSM to IDLE;
  - read pointer and FIFO pointers to 0, FIFO empty;
  - TX_SRC_RDY_N=1, TX_SOF_N=TX_EOF_N=TX_SOP_N=TX_EOP_N=1;
  - TX_RELLEN_DV=0, TX_RELLEN=0, TX_DATA=0, TX_REM=0;
  - TX_NEWLEN_RDY=0.
REQ-018 Buffer memory contents need not be reset. After RESET returns to 1, TX_NEWLEN_RDY SHALL be 1 on the next rising edge.

Verification (DATA_WIDTH=64, BLOCK_SIZE=512)
REQ-019 Basic frame: write words at byte addresses 0, 8 and 16, then NEWLEN=20 -> 3 words in order, SOF/SOP on word 1, EOF/EOP on word 3, TX_REM=3 on word 3, and TX_RELLEN=24 pulse one cycle after EOF is accepted.
REQ-020 Backpressure: TX_DST_RDY_N=1 for 5 cycles on word 2 -> outputs stable, no duplicated or dropped word.
REQ-021 Wrap-around: with the read pointer at 510, NEWLEN=32 -> words 510, 511, 0 and 1 sent, TX_RELLEN=32, read pointer ends at 2.
REQ-022 FIFO full: TX_DST_RDY_N held 1 and 20 NEWLEN=8 offered -> 17 accepted (1 popped + 16 queued), then TX_NEWLEN_RDY=0 until EOF is accepted.
REQ-023 Edge lengths: NEWLEN=0 then NEWLEN=8 -> only one frame, a single word with SOF=EOF=0 and TX_REM=7, and one TX_RELLEN=8.
REQ-024 Reset mid-frame: RESET=0 during SEND -> TX_SRC_RDY_N=1 immediately; after release, NEWLEN=8 sends the word at buffer address 0.
